// File: rtl/rr_arb_pkg.sv
// Shared constants and types for the round-robin mux-select arbiter.
package rr_arb_pkg;

  localparam int unsigned NUM_CH           = 4;
  localparam int unsigned SEL_W            = 2;
  localparam int unsigned HOLD_W           = 8;
  localparam int unsigned DEFAULT_MAX_HOLD = 8;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_mux_sel_arbiter_if.sv
// Request/grant bundle between the channel owners and the arbiter.
interface rr_mux_sel_arbiter_if;
  import rr_arb_pkg::*;

  logic [NUM_CH-1:0] req;
  logic              done;
  logic [SEL_W-1:0]  sel;
  logic [NUM_CH-1:0] grant;
  logic              valid;
  logic              timeout;

  // Requester side drives req/done and observes the grant.
  modport master (
    output req,
    output done,
    input  sel,
    input  grant,
    input  valid,
    input  timeout
  );

  // Arbiter side.
  modport slave (
    input  req,
    input  done,
    output sel,
    output grant,
    output valid,
    output timeout
  );

endinterface

// File: rtl/rr_pick.sv
// Rotate-priority encoder: first set request searching from ptr upward, modulo NUM_CH.
module rr_pick
  import rr_arb_pkg::*;
(
  input  logic [NUM_CH-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic              any_o,
  output logic [SEL_W-1:0]  idx_o
);

  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // SEL_W-bit addition wraps the search index naturally.
      if (!any_o && req_i[ptr_i + SEL_W'(i)]) begin
        any_o = 1'b1;
        idx_o = ptr_i + SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin arbiter driving the select of a 4:1 mux, with hold limit and
// a forced idle cycle between grants so the mux select can settle.
module rr_mux_sel_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEFAULT_MAX_HOLD  // legal range 1..255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rr_mux_sel_arbiter_if.slave  bus
);

  localparam logic [HOLD_W-1:0] HoldLimit = HOLD_W'(MAX_HOLD);

  arb_state_e        state_q, state_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] grant_q, grant_d;
  logic              valid_q, valid_d;
  logic              timeout_q, timeout_d;

  logic              pick_any;
  logic [SEL_W-1:0]  pick_idx;
  logic              rel_done, rel_drop, rel_hold;

  rr_pick u_pick (
    .req_i (bus.req),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      hold_q    <= '0;
      sel_q     <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      sel_q     <= sel_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign rel_done = bus.done;
  assign rel_drop = ~bus.req[sel_q];
  assign rel_hold = (hold_q == HoldLimit);

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    sel_d     = sel_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d = StBusy;
          sel_d   = pick_idx;
          grant_d = NUM_CH'(1) << pick_idx;
          valid_d = 1'b1;
          hold_d  = HOLD_W'(1);
        end
      end
      StBusy: begin
        if (rel_done || rel_drop || rel_hold) begin
          // sel is left alone so the mux output does not move while idle.
          state_d   = StIdle;
          grant_d   = '0;
          valid_d   = 1'b0;
          ptr_d     = sel_q + SEL_W'(1);
          hold_d    = '0;
          timeout_d = rel_hold && !rel_done && !rel_drop;
        end else if (hold_q != HoldLimit) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.sel     = sel_q;
    bus.grant   = grant_q;
    bus.valid   = valid_q;
    bus.timeout = timeout_q;
  end

endmodule
